// File: rtl/comm_arbiter.sv
// comm_arbiter: round-robin sharing of one UART command transmitter among
// NUM_REQ requesters. The winner's command is latched, a single send_cmd pulse
// starts the transmitter, and the requester is acked on the 0->1 edge of
// cmd_sent or by the watchdog if that edge never arrives.
//
// Handshakes (both sides are pulse/level, not valid/ready streams):
//   requester side  : req[i] is a level meaning "command pending" and req_cmd
//                     lane i must stay stable while it is high; ack[i] is a
//                     one-cycle pulse closing that transfer (completed or
//                     aborted, the latter flagged by timeout in the same cycle).
//                     req is only looked at while the arbiter is idle.
//   transmitter side: send_cmd is a one-cycle start pulse with cmd valid from
//                     grant until the next grant; completion is the rising
//                     edge of cmd_sent seen while waiting, never its level.
module comm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WDW           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  timeout,
    output logic                  busy,
    output logic [IDW-1:0]        gnt_id,
    output logic [15:0]           cmd,
    output logic                  send_cmd,
    input  logic                  cmd_sent,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int            SW      = IDW + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    state_t               state, state_n;
    logic [IDW-1:0]       ptr, ptr_n;
    logic [IDW-1:0]       gnt_n;
    logic [15:0]          cmd_n;
    logic                 send_n;
    logic [NUM_REQ-1:0]   ack_n;
    logic                 to_n;
    logic [WDW-1:0]       wd, wd_n;
    logic                 cmd_sent_q;
    logic                 rise;
    logic                 found;
    logic [IDW-1:0]       win;
    logic [SW-1:0]        sum;
    logic [IDW-1:0]       cand;

    assign rise      = cmd_sent & ~cmd_sent_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Round-robin search: first pending requester starting at ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            cand = sum[IDW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next registered-output values for the transfer FSM.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cmd_n   = cmd;
        gnt_n   = gnt_id;
        send_n  = 1'b0;
        ack_n   = '0;
        to_n    = 1'b0;
        wd_n    = wd;
        case (state)
            IDLE: begin
                if (found) begin
                    cmd_n   = req_cmd[16*int'(win) +: 16];
                    gnt_n   = win;
                    send_n  = 1'b1;
                    ptr_n   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A completion edge beats a simultaneous watchdog expiry.
                if (rise) begin
                    ack_n[gnt_id] = 1'b1;
                    state_n       = ACK;
                end else if (wd == WD_LAST) begin
                    ack_n[gnt_id] = 1'b1;
                    to_n          = 1'b1;
                    state_n       = ACK;
                end else if (wd != '1) begin
                    wd_n = wd + 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cmd        <= '0;
            gnt_id     <= '0;
            send_cmd   <= 1'b0;
            ack        <= '0;
            timeout    <= 1'b0;
            wd         <= '0;
            cmd_sent_q <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cmd        <= cmd_n;
            gnt_id     <= gnt_n;
            send_cmd   <= send_n;
            ack        <= ack_n;
            timeout    <= to_n;
            wd         <= wd_n;
            cmd_sent_q <= cmd_sent;
        end
    end

endmodule
